rdma_pkt_tx: RTL and testbench
==============================

RDMA_PKT_TX -- requirements
Module: rdma_pkt_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CREDITS, default 4, NoC link credits available at reset (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  remapped request offered by the upstream address-remap stage.
REQ-006 SHALL have port req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-007 SHALL have port req_addr  input  32  remote address (already remapped).
REQ-008 SHALL have port req_op  input  2  opcode (0 read, 1 write, 2-3 reserved, passed through).
REQ-009 SHALL have port req_len  input  8  transfer length in words.
REQ-010 SHALL have port flit_valid  output  1  one-cycle flit push to NoC router (no backpressure; credit-governed).
REQ-011 SHALL have port flit_data  output  34  [33:32] type (01 HEAD, 10 TAIL), [31:0] payload.
REQ-012 SHALL have port credit_ret  input  1  one credit returned per asserted cycle.
REQ-013 SHALL have port busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-014 SHALL store accepted requests {addr, op, len} in FIFO order; req_ready = !full, with no dependence on the same-cycle pop.
REQ-015 SHALL emit exactly two flits per request: HEAD payload {addr[31:28], op, len, 18'b0}, then TAIL payload = addr.
REQ-016 SHALL implement FSM states IDLE and TAIL.
- IDLE: FIFO non-empty && credits>0 -> register HEAD flit, decrement credits, go to TAIL.
- TAIL: credits>0 -> register TAIL flit, decrement credits, pop FIFO, go to IDLE.
- Otherwise hold the current state.
REQ-017 SHALL register flit_valid and flit_data. flit_valid is high for exactly one cycle per flit; flit_data holds its last value when flit_valid=0.
REQ-018 SHALL have the following latency: request accepted at edge E0 into an empty FIFO with credits -> HEAD valid after E1, TAIL after E2, next queued HEAD after E3 (no bubble).
REQ-019 SHALL keep a credit counter of width $clog2(CREDITS+1).
- credit_ret with no send: +1, saturating at CREDITS.
- Send with no credit_ret: -1.
- Simultaneous send and credit_ret: unchanged.
REQ-020 SHALL never emit a flit when credits==0; a packet stalled in TAIL resumes on the first available credit.
REQ-021 SHALL ignore req_op and req_len values beyond field formatting; no length-based behaviour.

Reset
REQ-022 SHALL, while rst_n=0, force: flit_valid=0, flit_data=0, req_ready=1, busy=0, FIFO empty, state IDLE, credits=CREDITS.
REQ-023 SHALL abandon any partial packet on reset mid-operation; no TAIL follows a pre-reset HEAD.

Configuration
REQ-024 SHALL, with RDMA_PKT_TX_STATS_EN defined, add output pkt_count (16 bits): reset 0, +1 per TAIL flit, wraps 0xFFFF->0.
REQ-025 SHALL, without RDMA_PKT_TX_STATS_EN, have no pkt_count port or counter logic.

Structure
REQ-026 SHALL take flit type encodings (FLIT_HEAD=2'b01, FLIT_TAIL=2'b10), opcode constants, the flit width (34) and the request struct typedef from the shared package rdma_pkg.
REQ-027 SHALL instantiate one sub-module, rdma_req_fifo (parameterised sync FIFO; push/pop/full/empty); the FSM and credit counter are local.

Verification
REQ-028 SHALL cover single packet: addr 0x80001000, op 1, len 4 -> HEAD payload 0x84100000 type 01, then TAIL payload 0x80001000 type 10; credits 4->2.
REQ-029 SHALL cover credit exhaustion: 3 requests, credit_ret held 0 -> 4 flits (2 packets) emitted, third packet held in IDLE; one credit_ret pulse -> HEAD only, stall in TAIL; second pulse -> TAIL.
REQ-030 SHALL cover FIFO full: with credits 0, push 5 requests back-to-back -> 4 accepted, req_ready=0 while 5th is offered, no flits.
REQ-031 SHALL cover credit boundaries: credit_ret while credits=4 -> stays 4; credit_ret on a send cycle -> count unchanged.
REQ-032 SHALL cover reset mid-packet: rst_n low one cycle after HEAD -> flit_valid=0, busy=0, req_ready=1, credits=4, no TAIL afterwards.
REQ-033 SHALL cover stats: with RDMA_PKT_TX_STATS_EN, 3 complete packets -> pkt_count=3.

Source files
------------

// File: rtl/rdma_pkg.sv
// Shared RDMA transmit definitions: flit layout, opcodes, request record.
// Latency: n/a (types, constants and pure formatting functions only).
// Backpressure: n/a.
package rdma_pkg;

    // Flit = 2-bit type + 32-bit payload.
    localparam int FLIT_W = 34;

    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    // Opcodes 2 and 3 are reserved and carried through untouched.
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    // One queued request as received from the address-remap stage.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  op;
        logic [7:0]  len;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TAIL = 1'b1
    } tx_state_t;

    // HEAD payload: top address nibble (routing hint), opcode, length, zero pad.
    function automatic logic [FLIT_W-1:0] head_flit(input logic [3:0] addr_hi,
                                                    input logic [1:0] op,
                                                    input logic [7:0] len);
        return {FLIT_HEAD, addr_hi, op, len, 18'b0};
    endfunction

    // TAIL payload: the full remote address.
    function automatic logic [FLIT_W-1:0] tail_flit(input logic [31:0] addr);
        return {FLIT_TAIL, addr};
    endfunction

endpackage

// File: rtl/rdma_req_fifo.sv
// Synchronous request FIFO, DEPTH entries (power of two) of WIDTH bits.
// Latency: a push is visible at pop_data/!empty the cycle after the push edge.
// Backpressure: full is derived from occupancy only; pushes while full are dropped.
//
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data (head
// entry, valid while !empty), full, empty.
module rdma_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rdma_pkt_tx.sv
// RDMA packet transmitter: queues remapped requests, emits HEAD+TAIL flit pairs to the NoC.
// Latency: request accepted at edge E0 into an idle block -> HEAD after E1, TAIL after E2.
// Backpressure: req_ready = !fifo_full; NoC side is credit-governed (no flit without a credit).
//
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_addr/req_op/req_len
// (request in); flit_valid/flit_data (registered flit out, data holds when idle);
// credit_ret (one credit per high cycle); busy (queue non-empty or packet in flight).
// Optional: define RDMA_PKT_TX_STATS_EN to add pkt_count (16-bit wrapping count of
// completed packets, bumped on every TAIL flit).
module rdma_pkt_tx
    import rdma_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_op,
    input  logic [7:0]        req_len,
    output logic              flit_valid,
    output logic [FLIT_W-1:0] flit_data,
    input  logic              credit_ret,
    output logic              busy
`ifdef RDMA_PKT_TX_STATS_EN
    ,
    output logic [15:0]       pkt_count
`endif
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [CW-1:0] credits;
    logic          has_credit;
    logic          send_head;
    logic          send_tail;
    logic          send;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_push;
    req_t          push_req;
    req_t          head_req;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    assign push_req  = {req_addr, req_op, req_len};
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    rdma_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Packet FSM. The request stays at the FIFO head until its TAIL goes
    // out, so TAIL reads the same entry HEAD did and the pop frees the slot.
    // ------------------------------------------------------------------
    assign has_credit = (credits != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        send_head = 1'b0;
        send_tail = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && has_credit) begin
                    send_head = 1'b1;
                    state_nxt = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (has_credit) begin
                    send_tail = 1'b1;
                    fifo_pop  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign send = send_head || send_tail;

    // ------------------------------------------------------------------
    // Registered flit output; data deliberately holds between flits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_valid <= 1'b0;
            flit_data  <= '0;
        end else begin
            flit_valid <= send;
            if (send_head) begin
                flit_data <= head_flit(head_req.addr[31:28], head_req.op, head_req.len);
            end else if (send_tail) begin
                flit_data <= tail_flit(head_req.addr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Link credits. A return on a send cycle cancels the spend; a return
    // with the counter already full is dropped (the router over-returned).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CRED_MAX;
        end else if (send && !credit_ret) begin
            credits <= credits - 1'b1;
        end else if (credit_ret && !send && (credits != CRED_MAX)) begin
            credits <= credits + 1'b1;
        end
    end

    assign busy = !fifo_empty || (state != ST_IDLE);

`ifdef RDMA_PKT_TX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (send_tail) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rdma_pkt_tx.sv
// Self-checking bench for rdma_pkt_tx: directed scenarios plus randomized
// traffic against a queue/arithmetic reference model.
module tb_rdma_pkt_tx;

    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_op = '0;
    logic [7:0]  req_len = '0;
    logic        flit_valid;
    logic [33:0] flit_data;
    logic        credit_ret = 1'b0;
    logic        busy;
`ifdef RDMA_PKT_TX_STATS_EN
    logic [15:0] pkt_count;
`endif

    always #5 clk = ~clk;

    rdma_pkt_tx #(
        .DEPTH   (DEPTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .req_len    (req_len),
        .flit_valid (flit_valid),
        .flit_data  (flit_data),
        .credit_ret (credit_ret),
        .busy       (busy)
`ifdef RDMA_PKT_TX_STATS_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected flit stream, credit count, queued requests.
    logic [33:0] exp_q[$];
    int          m_cred;
    int          occ;
    logic        m_ready;
    logic        m_busy;
    logic        e_send;
    logic [33:0] e_data;
    logic [33:0] last_data;

    function automatic logic [33:0] m_head(input logic [31:0] a, input logic [1:0] o,
                                           input logic [7:0] l);
        logic [3:0] hi;
        hi = a[31:28];
        return {2'b01, hi, o, l, 18'h0};
    endfunction

    function automatic logic [33:0] m_tail(input logic [31:0] a);
        return {2'b10, a};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_cred    = CREDITS;
        occ       = 0;
        m_ready   = 1'b1;
        m_busy    = 1'b0;
        e_send    = 1'b0;
        e_data    = '0;
        last_data = '0;
    endtask

    // One clock: drive inputs, take the edge, advance the model. Any work
    // pending before the edge must go out whenever a credit is held.
    task automatic step(input logic v, input logic [31:0] a, input logic [1:0] o,
                        input logic [7:0] l, input logic r);
        logic acc;
        req_valid  = v;
        req_addr   = a;
        req_op     = o;
        req_len    = l;
        credit_ret = r;
        acc = v && m_ready;
        @(posedge clk);
        #1;
        e_send = (exp_q.size() > 0) && (m_cred > 0);
        if (e_send) begin
            last_data = exp_q.pop_front();
            if (last_data[33:32] == 2'b10) occ--;
        end
        e_data = last_data;
        m_cred = m_cred - (e_send ? 1 : 0) + (r ? 1 : 0);
        if (m_cred > CREDITS) m_cred = CREDITS;
        if (acc) begin
            exp_q.push_back(m_head(a, o, l));
            exp_q.push_back(m_tail(a));
            occ++;
        end
        m_ready    = (occ < DEPTH);
        m_busy     = (occ != 0);
        req_valid  = 1'b0;
        credit_ret = 1'b0;
    endtask

    task automatic do_reset();
        req_valid  = 1'b0;
        credit_ret = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL rst_flit_valid got %b want 0", flit_valid); end
        checks++; if (flit_data !== 34'h0) begin errors++; $display("FAIL rst_flit_data got %h want 0", flit_data); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (dut.credits !== CW'(CREDITS)) begin errors++; $display("FAIL rst_credits got %0d want %0d", dut.credits, CREDITS); end
`ifdef RDMA_PKT_TX_STATS_EN
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count got %0d want 0", pkt_count); end
`endif
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 32'h8000_1000, 2'd1, 8'd4, 1'b0);
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL single_e0_valid got %b want 0", flit_valid); end
        step(1'b0, '0, '0, '0, 1'b0);
        checks++; if (flit_valid !== 1'b1 || flit_data !== 34'h1_8410_0000) begin errors++; $display("FAIL single_head got %b/%h want 1/%h", flit_valid, flit_data, 34'h1_8410_0000); end
        step(1'b0, '0, '0, '0, 1'b0);
        checks++; if (flit_valid !== 1'b1 || flit_data !== 34'h2_8000_1000) begin errors++; $display("FAIL single_tail got %b/%h want 1/%h", flit_valid, flit_data, 34'h2_8000_1000); end
        checks++; if (dut.credits !== CW'(2)) begin errors++; $display("FAIL single_credits got %0d want 2", dut.credits); end
        step(1'b0, '0, '0, '0, 1'b0);
        checks++; if (flit_valid !== 1'b0 || flit_data !== 34'h2_8000_1000) begin errors++; $display("FAIL single_hold got %b/%h want 0/%h", flit_valid, flit_data, 34'h2_8000_1000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [33:0] want [4];
        do_reset();
        want[0] = m_head(32'h1234_5678, 2'd0, 8'd9);
        want[1] = m_tail(32'h1234_5678);
        want[2] = m_head(32'hF000_00AA, 2'd3, 8'd200);
        want[3] = m_tail(32'hF000_00AA);
        step(1'b1, 32'h1234_5678, 2'd0, 8'd9, 1'b0);
        step(1'b1, 32'hF000_00AA, 2'd3, 8'd200, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (flit_valid !== 1'b1 || flit_data !== want[i]) begin
                errors++; $display("FAIL b2b_flit%0d got %b/%h want 1/%h", i, flit_valid, flit_data, want[i]);
            end
            step(1'b0, '0, '0, '0, 1'b0);
        end
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL b2b_after got %b want 0", flit_valid); end
    endtask

    task automatic test_credit_exhaust();
        int nflit;
        logic [33:0] seen;
        do_reset();
        nflit = 0;
        seen  = '0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hA000_0000 + 32'(i * 16), 2'd1, 8'(i), 1'b0);
            if (flit_valid === 1'b1) nflit++;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, '0, 1'b0);
            if (flit_valid === 1'b1) nflit++;
        end
        checks++; if (nflit != 4) begin errors++; $display("FAIL exhaust_flits got %0d want 4", nflit); end
        checks++; if (dut.credits !== '0) begin errors++; $display("FAIL exhaust_credits got %0d want 0", dut.credits); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exhaust_busy got %b want 1", busy); end
        nflit = 0;
        step(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, '0, 1'b0);
            if (flit_valid === 1'b1) begin nflit++; seen = flit_data; end
        end
        checks++; if (nflit != 1 || seen !== m_head(32'hA000_0020, 2'd1, 8'd2)) begin errors++; $display("FAIL exhaust_pulse1 got %0d/%h want 1/%h", nflit, seen, m_head(32'hA000_0020, 2'd1, 8'd2)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exhaust_stall_busy got %b want 1", busy); end
        nflit = 0;
        step(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, '0, 1'b0);
            if (flit_valid === 1'b1) begin nflit++; seen = flit_data; end
        end
        checks++; if (nflit != 1 || seen !== m_tail(32'hA000_0020)) begin errors++; $display("FAIL exhaust_pulse2 got %0d/%h want 1/%h", nflit, seen, m_tail(32'hA000_0020)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exhaust_done_busy got %b want 0", busy); end
    endtask

    // Runs with zero credits, as left behind by test_credit_exhaust.
    task automatic test_fifo_full();
        int acc;
        int nflit;
        acc   = 0;
        nflit = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", req_ready); end
            end
            if (req_ready === 1'b1) acc++;
            step(1'b1, 32'h5000_0000 + 32'(i), 2'(i), 8'(i + 1), 1'b0);
            if (flit_valid === 1'b1) nflit++;
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL full_accepted got %0d want 4", acc); end
        checks++; if (nflit != 0) begin errors++; $display("FAIL full_flits got %0d want 0", nflit); end
        for (int i = 0; i < 30; i++) begin
            step(1'b0, '0, '0, '0, (i % 2) == 0);
            checks++;
            if (flit_valid !== e_send || flit_data !== e_data) begin
                errors++; $display("FAIL full_drain%0d got %b/%h want %b/%h", i, flit_valid, flit_data, e_send, e_data);
            end
        end
        checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL full_drained left %0d busy %b want 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_credit_bounds();
        do_reset();
        step(1'b0, '0, '0, '0, 1'b1);
        checks++; if (dut.credits !== CW'(CREDITS)) begin errors++; $display("FAIL bound_sat got %0d want %0d", dut.credits, CREDITS); end
        step(1'b1, 32'h0BAD_F00D, 2'd0, 8'd1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1);
        checks++; if (flit_valid !== 1'b1 || dut.credits !== CW'(CREDITS)) begin errors++; $display("FAIL bound_sendret got %b/%0d want 1/%0d", flit_valid, dut.credits, CREDITS); end
        step(1'b0, '0, '0, '0, 1'b0);
        checks++; if (flit_valid !== 1'b1 || dut.credits !== CW'(CREDITS - 1)) begin errors++; $display("FAIL bound_send got %b/%0d want 1/%0d", flit_valid, dut.credits, CREDITS - 1); end
    endtask

    task automatic test_reset_mid();
        int nflit;
        do_reset();
        step(1'b1, 32'hCAFE_0000, 2'd1, 8'd7, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        checks++; if (flit_valid !== 1'b1 || flit_data[33:32] !== 2'b01) begin errors++; $display("FAIL mid_head got %b/%h want 1/head", flit_valid, flit_data); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (flit_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst got v%b b%b r%b want 0/0/1", flit_valid, busy, req_ready); end
        checks++; if (dut.credits !== CW'(CREDITS)) begin errors++; $display("FAIL mid_credits got %0d want %0d", dut.credits, CREDITS); end
        rst_n = 1'b1;
        model_reset();
        nflit = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, '0, 1'b0);
            if (flit_valid === 1'b1) nflit++;
        end
        checks++; if (nflit != 0) begin errors++; $display("FAIL mid_no_tail got %0d flits want 0", nflit); end
    endtask

    task automatic test_random();
        logic v;
        logic r;
        do_reset();
        for (int i = 0; i < 460; i++) begin
            v = (i < 400) && ($urandom_range(0, 2) != 0);
            r = (i >= 400) || ($urandom_range(0, 3) == 0);
            step(v, $urandom, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), r);
            checks++; if (flit_valid !== e_send) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, flit_valid, e_send); end
            checks++; if (flit_data !== e_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", i, flit_data, e_data); end
            checks++; if (req_ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, req_ready, m_ready); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, busy, m_busy); end
            checks++; if (dut.credits !== CW'(m_cred)) begin errors++; $display("FAIL rnd_credits cyc %0d got %0d want %0d", i, dut.credits, m_cred); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain left %0d want 0", exp_q.size()); end
    endtask

`ifdef RDMA_PKT_TX_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h7000_0000 + 32'(i), 2'd0, 8'd1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, '0, 1'b1);
        checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL stats_count got %0d want 3", pkt_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_exhaust();
        test_fifo_full();
        test_credit_bounds();
        test_reset_mid();
        test_random();
`ifdef RDMA_PKT_TX_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
